ext_irq_arbiter: RTL and testbench

Platform-level arbiter for external interrupt sources. It latches up to N_SRC level-sensitive device interrupt lines and applies per-source priority, enable and a global threshold. It drives the single machine external-interrupt-pending line, irq_o, into the CSR mip external bit. Software claims and completes interrupts through a small memory-mapped register port on the data bus.

---
 rtl/ext_irq_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ext_irq_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_arbiter.sv
// External interrupt arbiter.
// Each source has a gateway: idle, then pending, then in flight. The highest-priority pending,
// enabled source above the threshold drives irq_o. Software claims and completes interrupts
// through a small word-addressed register port.
module ext_irq_arbiter #(
    parameter int unsigned N_SRC  = 8,  // 1..15; IDs are 1..N_SRC and ID 0 means "none"
    parameter int unsigned PRIO_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] src_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [7:0]       addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             ack_o,
    output logic             irq_o
);

    // Word addresses (byte address >> 2). Priority words are 1..N_SRC.
    localparam logic [5:0] WordPend  = 6'h10;
    localparam logic [5:0] WordEn    = 6'h11;
    localparam logic [5:0] WordThr   = 6'h12;
    localparam logic [5:0] WordClaim = 6'h13;

    // Per-source state. Bit k of each vector is source ID k+1.
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  inflight_q, inflight_d;
    logic [N_SRC-1:0]  enable_q, enable_d;
    logic [PRIO_W-1:0] prio_q [N_SRC];
    logic [PRIO_W-1:0] prio_d [N_SRC];
    logic [PRIO_W-1:0] thresh_q, thresh_d;

    // Bus response and interrupt output registers.
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q;
    logic        irq_q, irq_d;

    // Arbitration result.
    logic [N_SRC-1:0]  cand;
    logic [3:0]        best_id;
    logic [PRIO_W-1:0] best_prio;

    // Bus decode.
    logic [5:0] word_addr;
    logic       acc_rd;
    logic       acc_wr;
    logic       claim;
    logic       complete;

    // Address byte-offset bits and the unused upper write-data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    assign word_addr = addr_i[7:2];
    assign acc_rd    = req_i & ~we_i;
    assign acc_wr    = req_i & we_i;
    assign claim     = acc_rd && (word_addr == WordClaim);
    assign complete  = acc_wr && (word_addr == WordClaim);

    // Pick the highest-priority candidate. The ascending scan with a strict compare
    // keeps the lowest ID on ties.
    always_comb begin
        best_id   = 4'd0;
        best_prio = '0;
        cand      = '0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            cand[k] = pending_q[k] & enable_q[k] & (prio_q[k] > thresh_q);
            if (cand[k] && (prio_q[k] > best_prio)) begin
                best_id   = 4'(k + 1);
                best_prio = prio_q[k];
            end
        end
    end

    // Gateway next state. src_i is only looked at while a source is idle, so a claim
    // always wins over a simultaneous src_i, and a completed source that is still
    // asserting re-pends one edge later.
    always_comb begin
        pending_d  = pending_q;
        inflight_d = inflight_q;
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (pending_q[k]) begin
                if (claim && (best_id == 4'(k + 1))) begin
                    pending_d[k]  = 1'b0;
                    inflight_d[k] = 1'b1;
                end
            end else if (inflight_q[k]) begin
                if (complete && (wdata_i[3:0] == 4'(k + 1))) begin
                    inflight_d[k] = 1'b0;
                end
            end else if (src_i[k]) begin
                pending_d[k] = 1'b1;
            end
        end
    end

    // Configuration register writes: priorities, enable mask and threshold.
    always_comb begin
        prio_d   = prio_q;
        enable_d = enable_q;
        thresh_d = thresh_q;
        if (acc_wr) begin
            for (int k = 0; k < int'(N_SRC); k++) begin
                if (word_addr == 6'(k + 1)) begin
                    prio_d[k] = wdata_i[PRIO_W-1:0];
                end
            end
            if (word_addr == WordEn) begin
                // Bit 0 of the mask (ID 0) has no storage, so it always reads 0.
                for (int k = 0; k < int'(N_SRC); k++) begin
                    enable_d[k] = wdata_i[k+1];
                end
            end
            if (word_addr == WordThr) begin
                thresh_d = wdata_i[PRIO_W-1:0];
            end
        end
    end

    // Read data mux. It is registered with ack and held at 0 when there is no read.
    always_comb begin
        rdata_d = '0;
        if (acc_rd) begin
            for (int k = 0; k < int'(N_SRC); k++) begin
                if (word_addr == 6'(k + 1)) begin
                    rdata_d[PRIO_W-1:0] = prio_q[k];
                end
            end
            if (word_addr == WordPend) begin
                for (int k = 0; k < int'(N_SRC); k++) begin
                    rdata_d[k+1] = pending_q[k];
                end
            end
            if (word_addr == WordEn) begin
                for (int k = 0; k < int'(N_SRC); k++) begin
                    rdata_d[k+1] = enable_q[k];
                end
            end
            if (word_addr == WordThr) begin
                rdata_d[PRIO_W-1:0] = thresh_q;
            end
            if (word_addr == WordClaim) begin
                rdata_d[3:0] = best_id;
            end
        end
    end

    // Interrupt request follows the current arbitration result by one cycle.
    always_comb begin
        irq_d = (best_id != 4'd0);
    end

    // State registers. The synchronous reset drops any in-flight claim.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            inflight_q <= '0;
            enable_q   <= '0;
            thresh_q   <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            for (int k = 0; k < int'(N_SRC); k++) begin
                prio_q[k] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            enable_q   <= enable_d;
            thresh_q   <= thresh_d;
            rdata_q    <= rdata_d;
            ack_q      <= req_i;
            irq_q      <= irq_d;
            for (int k = 0; k < int'(N_SRC); k++) begin
                prio_q[k] <= prio_d[k];
            end
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// Directed self-checking bench for ext_irq_arbiter (N_SRC=8, PRIO_W=3).
module tb_ext_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  src;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;

    int tests  = 0;
    int failed = 0;
    logic [31:0] rd;

    ext_irq_arbiter #(
        .N_SRC (8),
        .PRIO_W(3)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .src_i  (src),
        .req_i  (req),
        .we_i   (we),
        .addr_i (addr),
        .wdata_i(wdata),
        .rdata_o(rdata),
        .ack_o  (ack),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        check("write_ack", {31'd0, ack}, 32'd1);
        check("write_rdata", rdata, 32'd0);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a; wdata = '0;
        tick();
        check("read_ack", {31'd0, ack}, 32'd1);
        d = rdata;
        req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; src = '0; addr = '0; wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

        // Reset then idle.
        do_reset();
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        tick();
        check("idle_ack", {31'd0, ack}, 32'd0);
        bus_read(8'h00, rd); check("rd_addr0", rd, 32'd0);
        bus_read(8'h04, rd); check("rd_prio1", rd, 32'd0);
        bus_read(8'h40, rd); check("rd_pend", rd, 32'd0);
        bus_read(8'h44, rd); check("rd_en", rd, 32'd0);
        bus_read(8'h48, rd); check("rd_thr", rd, 32'd0);
        bus_read(8'h80, rd); check("rd_unmapped", rd, 32'd0);
        src = 8'h01;
        tick();
        src = 8'h00;
        tick();
        bus_read(8'h40, rd); check("prio0_pend", rd, 32'h2);
        check("prio0_irq", {31'd0, irq}, 32'd0);

        // Basic flow on ID 3.
        do_reset();
        bus_write(8'h0C, 32'd5);
        bus_write(8'h44, 32'h08);
        bus_write(8'h48, 32'd0);
        bus_read(8'h0C, rd); check("rd_prio3", rd, 32'd5);
        bus_read(8'h44, rd); check("rd_en3", rd, 32'h08);
        src = 8'h04;
        tick();
        src = 8'h00;
        check("basic_irq_n", {31'd0, irq}, 32'd0);
        tick();
        check("basic_irq_n1", {31'd0, irq}, 32'd1);
        bus_read(8'h4C, rd); check("basic_claim", rd, 32'd3);
        tick();
        check("basic_irq_drop", {31'd0, irq}, 32'd0);
        bus_read(8'h40, rd); check("basic_pend_claimed", rd, 32'd0);
        bus_write(8'h4C, 32'd3);
        src = 8'h04;
        tick();
        src = 8'h00;
        bus_read(8'h40, rd); check("basic_repend", rd, 32'h08);
        bus_write(8'h40, 32'hFFFF_FFFF);
        bus_read(8'h40, rd); check("pend_ro", rd, 32'h08);

        // Priority and tie-break.
        do_reset();
        bus_write(8'h08, 32'd4);
        bus_write(8'h14, 32'd4);
        bus_write(8'h1C, 32'd6);
        bus_write(8'h44, 32'hA5);
        bus_read(8'h44, rd); check("en_bit0", rd, 32'hA4);
        src = 8'h52;
        tick();
        src = 8'h00;
        bus_read(8'h4C, rd); check("claim_1st", rd, 32'd7);
        bus_read(8'h4C, rd); check("claim_2nd", rd, 32'd2);
        bus_read(8'h4C, rd); check("claim_3rd", rd, 32'd5);
        bus_read(8'h4C, rd); check("claim_none", rd, 32'd0);
        bus_read(8'h40, rd); check("tie_pend", rd, 32'd0);

        // Threshold.
        do_reset();
        bus_write(8'h10, 32'd2);
        bus_write(8'h44, 32'h10);
        bus_write(8'h48, 32'd2);
        src = 8'h08;
        tick();
        src = 8'h00;
        tick();
        tick();
        check("thr_block", {31'd0, irq}, 32'd0);
        bus_write(8'h48, 32'd1);
        check("thr_same_cycle", {31'd0, irq}, 32'd0);
        tick();
        check("thr_pass", {31'd0, irq}, 32'd1);
        bus_read(8'h48, rd); check("rd_thr1", rd, 32'd1);

        // Held level on ID 1.
        do_reset();
        bus_write(8'h04, 32'd3);
        bus_write(8'h44, 32'h02);
        src = 8'h01;
        tick();
        tick();
        check("held_irq", {31'd0, irq}, 32'd1);
        bus_read(8'h4C, rd); check("held_claim", rd, 32'd1);
        bus_write(8'h4C, 32'd6);
        bus_read(8'h40, rd); check("held_wrong_id", rd, 32'd0);
        bus_write(8'h4C, 32'd0);
        bus_read(8'h40, rd); check("held_id0", rd, 32'd0);
        bus_write(8'h4C, 32'd1);
        bus_read(8'h40, rd); check("held_idle_edge", rd, 32'd0);
        bus_read(8'h40, rd); check("held_repend", rd, 32'h2);

        // Claim while src_i is still high for the same ID.
        bus_read(8'h4C, rd); check("same_claim", rd, 32'd1);
        bus_read(8'h40, rd); check("same_no_dup", rd, 32'd0);
        tick();
        check("same_irq_low", {31'd0, irq}, 32'd0);

        // Reset while in flight, then normal operation again.
        do_reset();
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        bus_read(8'h04, rd); check("mid_rst_prio", rd, 32'd0);
        bus_read(8'h44, rd); check("mid_rst_en", rd, 32'd0);
        bus_read(8'h40, rd); check("mid_rst_pend", rd, 32'd0);
        bus_write(8'h04, 32'd3);
        bus_write(8'h44, 32'h02);
        src = 8'h01;
        tick();
        src = 8'h00;
        tick();
        check("post_rst_irq", {31'd0, irq}, 32'd1);
        bus_read(8'h4C, rd); check("post_rst_claim", rd, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
